// File: rtl/tft_pkg.sv
// Shared ILI9341 definitions: panel defaults, command bytes, streamer FSM states
// and the address-window header table.
package tft_pkg;

    localparam int LCD_W_DEF = 240;
    localparam int LCD_H_DEF = 320;

    localparam logic [7:0] ILI_CASET = 8'h2A;
    localparam logic [7:0] ILI_RASET = 8'h2B;
    localparam logic [7:0] ILI_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_HDR,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_CS_HOLD,
        ST_GAP
    } stream_state_e;

    // Returns {dc, byte} for header position idx (0..10).
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx,
                                            input logic [15:0] w_end,
                                            input logic [15:0] h_end);
        case (idx)
            4'd0:       hdr_byte = {1'b0, ILI_CASET};
            4'd1, 4'd2: hdr_byte = {1'b1, 8'h00};
            4'd3:       hdr_byte = {1'b1, w_end[15:8]};
            4'd4:       hdr_byte = {1'b1, w_end[7:0]};
            4'd5:       hdr_byte = {1'b0, ILI_RASET};
            4'd6, 4'd7: hdr_byte = {1'b1, 8'h00};
            4'd8:       hdr_byte = {1'b1, h_end[15:8]};
            4'd9:       hdr_byte = {1'b1, h_end[7:0]};
            default:    hdr_byte = {1'b0, ILI_RAMWR};
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 SPI byte shifter: SCK generation, shift register and bit counter.
// ready is combinational so a byte loaded on the final falling edge follows with no gap.
module spi_byte_tx #(
    parameter int SPI_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       dc_in,
    output logic       ready,
    output logic       sck,
    output logic       mosi,
    output logic       dc
);

    localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SPI_DIV - 1);

    logic          act_q;
    logic [7:0]    sh_q;
    logic [2:0]    bit_q;
    logic [DW-1:0] div_q;
    logic          sck_q, mosi_q, dc_q;
    logic          tick;

    assign tick  = (div_q == DIV_LAST);
    assign ready = !act_q || (sck_q && tick && bit_q == 3'd7);
    assign sck   = sck_q;
    assign mosi  = mosi_q;
    assign dc    = dc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q  <= 1'b0;
            sh_q   <= '0;
            bit_q  <= '0;
            div_q  <= '0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            dc_q   <= 1'b0;
        end else if (load && ready) begin
            act_q  <= 1'b1;
            sh_q   <= byte_in;
            bit_q  <= '0;
            div_q  <= '0;
            sck_q  <= 1'b0;
            mosi_q <= byte_in[7];
            dc_q   <= dc_in;
        end else if (act_q) begin
            if (!tick) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    // falling edge: next bit goes out at the start of its low phase
                    sck_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        act_q <= 1'b0;
                    end else begin
                        bit_q  <= bit_q + 1'b1;
                        sh_q   <= {sh_q[6:0], 1'b0};
                        mosi_q <= sh_q[6];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_frame_streamer.sv
// Streams one ILI9341 frame: CASET/RASET/RAMWR header then LCD_W*LCD_H RGB565 pixels.
// Define ILI9341_STREAM_CONTINUOUS_EN to restart frames back-to-back after the first start.
module ili9341_frame_streamer
    import tft_pkg::*;
#(
    parameter int LCD_W   = LCD_W_DEF,
    parameter int LCD_H   = LCD_H_DEF,
    parameter int SPI_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] pixel_color,
    output logic        pixel_req,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_dc,
    output logic        busy,
    output logic        frame_done
);

    localparam int NPIX = LCD_W * LCD_H;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(2 * SPI_DIV + 1);
    localparam logic [PW-1:0] PIX_LAST   = PW'(NPIX - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SPI_DIV - 1);
    localparam logic [CW-1:0] HOLD_END   = CW'(SPI_DIV);
    localparam logic [CW-1:0] GAP_LAST   = CW'(2 * SPI_DIV - 1);
    localparam logic [15:0]   W_END      = 16'(LCD_W - 1);
    localparam logic [15:0]   H_END      = 16'(LCD_H - 1);

    stream_state_e state_q;
    logic [3:0]    hdr_cnt_q;
    logic [PW-1:0] pix_cnt_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   px_q;
    logic          cs_n_q, busy_q, done_q, req_q;
    logic          tx_ready, tx_load;
    logic [8:0]    tx_word;

    // Load is combinational against ready so bytes run back-to-back.
    always_comb begin
        tx_load = 1'b0;
        tx_word = hdr_byte(hdr_cnt_q, W_END, H_END);
        case (state_q)
            ST_CS_SETUP: tx_load = tx_ready && (cnt_q == SETUP_LAST);
            ST_HDR:      tx_load = tx_ready;
            ST_PIX_HI: begin
                tx_load = tx_ready;
                tx_word = {1'b1, pixel_color[15:8]};
            end
            ST_PIX_LO: begin
                tx_load = tx_ready;
                tx_word = {1'b1, px_q[7:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hdr_cnt_q <= '0;
            pix_cnt_q <= '0;
            cnt_q     <= '0;
            px_q      <= '0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hdr_cnt_q <= '0;
                    pix_cnt_q <= '0;
                    cnt_q     <= '0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        state_q <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (tx_load) begin
                        hdr_cnt_q <= 4'd1;
                        state_q   <= ST_HDR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HDR: begin
                    if (tx_load) begin
                        hdr_cnt_q <= hdr_cnt_q + 1'b1;
                        if (hdr_cnt_q == 4'd10) state_q <= ST_PIX_HI;
                    end
                end
                ST_PIX_HI: begin
                    if (tx_load) begin
                        px_q    <= pixel_color;
                        req_q   <= 1'b1;
                        state_q <= ST_PIX_LO;
                    end
                end
                ST_PIX_LO: begin
                    if (tx_load) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                        cnt_q     <= '0;
                        state_q   <= (pix_cnt_q == PIX_LAST) ? ST_CS_HOLD : ST_PIX_HI;
                    end
                end
                ST_CS_HOLD: begin
                    // count starts on the edge the final SCK fall completes
                    if (tx_ready) begin
                        if (cnt_q == HOLD_END) begin
                            cs_n_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        done_q <= 1'b1;
`ifdef ILI9341_STREAM_CONTINUOUS_EN
                        cs_n_q    <= 1'b0;
                        cnt_q     <= '0;
                        hdr_cnt_q <= '0;
                        pix_cnt_q <= '0;
                        state_q   <= ST_CS_SETUP;
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    spi_byte_tx #(.SPI_DIV(SPI_DIV)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tx_load),
        .byte_in (tx_word[7:0]),
        .dc_in   (tx_word[8]),
        .ready   (tx_ready),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .dc      (spi_dc)
    );

    assign spi_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pixel_req  = req_q;

endmodule
